// File: rtl/sm_trace_pkg.sv
// Shared record layout and constants for the schoolMIPS retirement trace capture.
package sm_trace_pkg;
  localparam int TRACE_CNT_W = 32;

  typedef struct packed {
    logic [TRACE_CNT_W-1:0] cycle;
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic                   we;
    logic [4:0]             wa;
    logic [31:0]            wd;
  } trace_rec_t;

  localparam int          TRACE_REC_W = $bits(trace_rec_t);
  localparam logic [15:0] DROP_SAT    = 16'hFFFF;
endpackage

// File: rtl/sm_trace_fifo.sv
// First-word-fall-through FIFO of trace records; head is visible on dout with no read latency.
module sm_trace_fifo
  import sm_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  trace_rec_t               din,
  output trace_rec_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  trace_rec_t      mem [DEPTH];
  logic [AW-1:0]   wrPtr, rdPtr;
  logic            pushOk, popOk;

  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign popOk  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign pushOk = push & (~full | popOk);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/sm_trace_capture.sv
// Samples core pc/instr/regfile write each clk, stamps a cycle number and queues it for the logger.
module sm_trace_capture
  import sm_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STOP_CYCLES = 200,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     rf_we_i,
  input  logic [4:0]               rf_wa_i,
  input  logic [31:0]              rf_wd_i,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W-1:0]         rec_cycle,
  output logic [31:0]              rec_pc,
  output logic [31:0]              rec_instr,
  output logic                     rec_we,
  output logic [4:0]               rec_wa,
  output logic [31:0]              rec_wd,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              dropped,
  output logic                     stop_o
);
  logic [CNT_W-1:0] cycCnt;
  logic [31:0]      capCnt;
  logic             cap, pop, fifoFull, fifoEmpty, stopHit;
  trace_rec_t       newRec, head;

  assign cap     = en & ~stop_o;
  assign pop     = rec_valid & rec_ready;
  assign stopHit = (STOP_CYCLES != 0) && (capCnt + 32'd1 == 32'(STOP_CYCLES));

  always_comb begin
    newRec       = '0;
    newRec.cycle = TRACE_CNT_W'(cycCnt);
    newRec.pc    = pc_i;
    newRec.instr = instr_i;
    newRec.we    = rf_we_i;
    newRec.wa    = rf_wa_i & {5{rf_we_i}};
    newRec.wd    = rf_wd_i & {32{rf_we_i}};
  end

  sm_trace_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .pop   (pop),
    .din   (newRec),
    .dout  (head),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (level)
  );

  // Memory is not reset, so outputs are zeroed whenever there is no head.
  assign rec_valid = ~fifoEmpty;
  assign rec_cycle = rec_valid ? head.cycle[CNT_W-1:0] : '0;
  assign rec_pc    = rec_valid ? head.pc    : '0;
  assign rec_instr = rec_valid ? head.instr : '0;
  assign rec_we    = rec_valid & head.we;
  assign rec_wa    = rec_valid ? head.wa    : '0;
  assign rec_wd    = rec_valid ? head.wd    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycCnt  <= '0;
      capCnt  <= '0;
      dropped <= '0;
      stop_o  <= 1'b0;
    end else begin
      if (cap) begin
        cycCnt <= cycCnt + 1'b1;
        capCnt <= capCnt + 32'd1;
        if (stopHit) stop_o <= 1'b1;
        if (fifoFull && !pop && dropped != DROP_SAT) dropped <= dropped + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_sm_trace_capture.sv
// Directed bench for sm_trace_capture: streaming, masking, overflow, full+pop, stop and async reset.
module tb_sm_trace_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] pc_i = '0, instr_i = '0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_wa_i = '0;
  logic [31:0] rf_wd_i = '0;
  logic        rec_valid, rec_ready = 1'b0;
  logic [31:0] rec_cycle, rec_pc, rec_instr, rec_wd;
  logic        rec_we;
  logic [4:0]  rec_wa;
  logic [4:0]  level;
  logic [15:0] dropped;
  logic        stop_o;

  int total = 0;
  int bad   = 0;

  sm_trace_capture #(.DEPTH(16), .STOP_CYCLES(200), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_i(pc_i), .instr_i(instr_i),
    .rf_we_i(rf_we_i), .rf_wa_i(rf_wa_i), .rf_wd_i(rf_wd_i),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_cycle(rec_cycle),
    .rec_pc(rec_pc), .rec_instr(rec_instr), .rec_we(rec_we), .rec_wa(rec_wa),
    .rec_wd(rec_wd), .level(level), .dropped(dropped), .stop_o(stop_o)
  );

  always #5 clk = ~clk;

  task automatic rst_pulse();
    @(negedge clk);
    en = 1'b0; rec_ready = 1'b0; rf_we_i = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rec_ready = 1'b1; pc_i = 32'h40;
    #12;
    total++;
    if (rec_valid !== 1'b0 || level !== 5'd0 || dropped !== 16'd0 || stop_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b level=%0d dropped=%0d stop=%b, want 0 0 0 0", rec_valid, level, dropped, stop_o);
    end
    total++;
    if (rec_cycle !== 32'd0 || rec_pc !== 32'd0 || rec_wd !== 32'd0) begin
      bad++;
      $display("FAIL reset_rec: cycle=%0d pc=%h wd=%h, want zeros", rec_cycle, rec_pc, rec_wd);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    en = 1'b1; rec_ready = 1'b1; pc_i = 32'd0; instr_i = 32'h2000_0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (rec_valid !== 1'b1 || rec_cycle !== 32'(k) || rec_pc !== 32'(4*k) || level !== 5'd1 || dropped !== 16'd0) begin
        bad++;
        $display("FAIL stream[%0d]: valid=%b cycle=%0d pc=%0d level=%0d dropped=%0d, want 1 %0d %0d 1 0", k, rec_valid, rec_cycle, rec_pc, level, dropped, k, 4*k);
      end
      pc_i = 32'(4*(k+1));
    end
  endtask

  task automatic test_mask();
    rf_we_i = 1'b0; rf_wa_i = 5'd9; rf_wd_i = 32'hDEAD;
    @(negedge clk);
    total++;
    if (rec_we !== 1'b0 || rec_wa !== 5'd0 || rec_wd !== 32'd0 || rec_cycle !== 32'd8) begin
      bad++;
      $display("FAIL mask_we0: we=%b wa=%0d wd=%h cycle=%0d, want 0 0 0 8", rec_we, rec_wa, rec_wd, rec_cycle);
    end
    rf_we_i = 1'b1;
    @(negedge clk);
    total++;
    if (rec_we !== 1'b1 || rec_wa !== 5'd9 || rec_wd !== 32'hDEAD || rec_cycle !== 32'd9) begin
      bad++;
      $display("FAIL mask_we1: we=%b wa=%0d wd=%h cycle=%0d, want 1 9 dead 9", rec_we, rec_wa, rec_wd, rec_cycle);
    end
    rf_we_i = 1'b0; en = 1'b0;
  endtask

  task automatic test_overflow();
    rst_pulse();
    en = 1'b1; rec_ready = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (level !== 5'd16 || dropped !== 16'd4 || rec_cycle !== 32'd0) begin
      bad++;
      $display("FAIL overflow_fill: level=%0d dropped=%0d head=%0d, want 16 4 0", level, dropped, rec_cycle);
    end
    en = 1'b0; rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rec_valid !== 1'b1 || rec_cycle !== 32'(i)) begin
        bad++;
        $display("FAIL overflow_drain[%0d]: valid=%b cycle=%0d, want 1 %0d", i, rec_valid, rec_cycle, i);
      end
      @(negedge clk);
    end
    total++;
    if (rec_valid !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL overflow_empty: valid=%b level=%0d, want 0 0", rec_valid, level);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    rst_pulse();
    en = 1'b1; rec_ready = 1'b0;
    repeat (18) @(negedge clk);
    rec_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      total++;
      if (level !== 5'd16 || dropped !== 16'd2 || rec_cycle !== 32'(j)) begin
        bad++;
        $display("FAIL full_pop[%0d]: level=%0d dropped=%0d head=%0d, want 16 2 %0d", j, level, dropped, rec_cycle, j);
      end
    end
    en = 1'b0; rec_ready = 1'b0;
  endtask

  task automatic test_stop();
    int n = 0;
    logic [31:0] last = '1;
    rst_pulse();
    en = 1'b1; rec_ready = 1'b1;
    for (int k = 0; k < 210; k++) begin
      @(negedge clk);
      if (k == 198 || k == 199 || k == 205) begin
        total++;
        if (stop_o !== (k >= 199)) begin
          bad++;
          $display("FAIL stop_rise[%0d]: stop=%b, want %b", k, stop_o, (k >= 199));
        end
      end
      if (rec_valid) begin
        total++;
        if (rec_cycle !== 32'(n)) begin
          bad++;
          $display("FAIL stop_order[%0d]: cycle=%0d, want %0d", n, rec_cycle, n);
        end
        last = rec_cycle;
        n++;
      end
    end
    total++;
    if (n !== 200 || last !== 32'd199 || level !== 5'd0) begin
      bad++;
      $display("FAIL stop_count: records=%0d last=%0d level=%0d, want 200 199 0", n, last, level);
    end
    en = 1'b0; rec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst_pulse();
    en = 1'b1; rec_ready = 1'b0;
    repeat (200) @(negedge clk);
    total++;
    if (stop_o !== 1'b1 || level !== 5'd16 || dropped !== 16'd184) begin
      bad++;
      $display("FAIL mid_pre_stop: stop=%b level=%0d dropped=%0d, want 1 16 184", stop_o, level, dropped);
    end
    rec_ready = 1'b1;
    repeat (9) @(negedge clk);
    rec_ready = 1'b0;
    total++;
    if (level !== 5'd7 || stop_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_level: level=%0d stop=%b, want 7 1", level, stop_o);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (level !== 5'd0 || rec_valid !== 1'b0 || stop_o !== 1'b0 || dropped !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: level=%0d valid=%b stop=%b dropped=%0d, want 0 0 0 0", level, rec_valid, stop_o, dropped);
    end
    rst = 1'b0; en = 1'b1; pc_i = 32'h100;
    @(negedge clk);
    total++;
    if (rec_valid !== 1'b1 || rec_cycle !== 32'd0 || rec_pc !== 32'h100 || level !== 5'd1) begin
      bad++;
      $display("FAIL mid_restart: valid=%b cycle=%0d pc=%h level=%0d, want 1 0 100 1", rec_valid, rec_cycle, rec_pc, level);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mask();
    test_overflow();
    test_full_pop();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
